// File: rtl/pwm_pkg.sv
// Constants shared by the PWM channel bank: register map addresses and the
// period value loaded at reset.
package pwm_pkg;

    localparam logic [2:0] ADDR_PERIOD = 3'd6;
    localparam logic [2:0] ADDR_POL    = 3'd7;

    // All ones; truncated to WIDTH at the point of use, giving 2^WIDTH-1.
    localparam logic [31:0] RESET_PERIOD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_channel_cmp.sv
// Per-channel duty compare with registered, polarity-adjusted PWM output.
module pwm_channel_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] duty_active,
    input  logic             pol_active,
    input  logic             pol_shadow,
    output logic             pwm_out
);

    logic pwm_out_reg;

    // While disabled the output idles at the programmed (shadow) polarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out_reg <= 1'b0;
        end else if (!en) begin
            pwm_out_reg <= pol_shadow;
        end else begin
            pwm_out_reg <= (count < duty_active) ^ pol_active;
        end
    end

    assign pwm_out = pwm_out_reg;

endmodule

// File: rtl/pwm_channel_bank.sv
// Bank of NUM_CH PWM channels sharing one strobe-driven counter, with
// double-buffered duty/period/polarity registers swapped at each period wrap.
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic              en,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    logic [WIDTH-1:0]  count_reg;
    logic [WIDTH-1:0]  period_shadow_reg;
    logic [WIDTH-1:0]  period_active_reg;
    logic [NUM_CH-1:0] pol_shadow_reg;
    logic [NUM_CH-1:0] pol_active_reg;
    logic              period_start_reg;
    logic              wrap;
    logic              load_active;

    assign wrap        = en && strobe && (count_reg == period_active_reg);
    // Holding the bank disabled keeps the active set tracking the shadows,
    // so enabling starts immediately with the latest programmed values.
    assign load_active = wrap || !en;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg         <= '0;
            period_shadow_reg <= WIDTH'(RESET_PERIOD);
            period_active_reg <= WIDTH'(RESET_PERIOD);
            pol_shadow_reg    <= '0;
            pol_active_reg    <= '0;
            period_start_reg  <= 1'b0;
        end else begin
            if (wr_en && wr_addr == ADDR_PERIOD) begin
                period_shadow_reg <= wr_data;
            end
            if (wr_en && wr_addr == ADDR_POL) begin
                pol_shadow_reg <= wr_data[NUM_CH-1:0];
            end
            if (load_active) begin
                period_active_reg <= period_shadow_reg;
                pol_active_reg    <= pol_shadow_reg;
            end
            if (!en) begin
                count_reg <= '0;
            end else if (strobe) begin
                count_reg <= wrap ? '0 : count_reg + WIDTH'(1);
            end
            period_start_reg <= wrap;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] duty_shadow_reg;
            logic [WIDTH-1:0] duty_active_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    duty_shadow_reg <= '0;
                    duty_active_reg <= '0;
                end else begin
                    if (wr_en && wr_addr == 3'(gi)) begin
                        duty_shadow_reg <= wr_data;
                    end
                    if (load_active) begin
                        duty_active_reg <= duty_shadow_reg;
                    end
                end
            end

            pwm_channel_cmp #(
                .WIDTH(WIDTH)
            ) u_cmp (
                .clk         (clk),
                .reset       (reset),
                .en          (en),
                .count       (count_reg),
                .duty_active (duty_active_reg),
                .pol_active  (pol_active_reg[gi]),
                .pol_shadow  (pol_shadow_reg[gi]),
                .pwm_out     (pwm_out[gi])
            );
        end
    endgenerate

    assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed testbench for pwm_channel_bank with hand-computed expected patterns.
module tb_pwm_channel_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              strobe = 1'b0;
    logic              en = 1'b0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int check_count = 0;
    int error_count = 0;

    pwm_channel_bank #(
        .NUM_CH(NUM_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .strobe       (strobe),
        .en           (en),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0]  exp_s1_pwm;
        logic [7:0]  exp_s1_ps;
        logic [7:0]  exp_s3_pwm;
        logic [15:0] exp_s4_pwm;
        logic [7:0]  exp_s5_pwm;
        logic [7:0]  exp_s5_ps;

        exp_s1_pwm = 8'b0011_0011;
        exp_s1_ps  = 8'b1000_1000;
        exp_s3_pwm = 8'h13;
        exp_s4_pwm = 16'h7331;
        exp_s5_pwm = 8'b0110_0110;
        exp_s5_ps  = 8'b0100_0100;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("reset pwm_out", 32'(pwm_out), 32'h0);
        check("reset period_start", 32'(period_start), 32'h0);
        check("reset count", 32'(dut.count_reg), 32'h0);
        check("reset period", 32'(dut.period_active_reg), 32'd255);

        // Scenario 1: period=3, duty0=2, strobe every cycle
        write_reg(3'd6, 8'd3);
        write_reg(3'd0, 8'd2);
        step();
        en     = 1'b1;
        strobe = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("s1 pwm0 c%0d", i), 32'(pwm_out[0]), 32'(exp_s1_pwm[i]));
            check($sformatf("s1 period_start c%0d", i), 32'(period_start), 32'(exp_s1_ps[i]));
        end

        // Scenario 3: duty0=1 written mid-period takes effect at the next wrap
        for (int i = 0; i < 8; i++) begin
            wr_en   = (i == 1);
            wr_addr = 3'd0;
            wr_data = 8'd1;
            step();
            check($sformatf("s3 pwm0 c%0d", i), 32'(pwm_out[0]), 32'(exp_s3_pwm[i]));
        end
        wr_en = 1'b0;

        // Scenario 4: duty0 2->3 written on the wrap edge is delayed one period
        for (int i = 0; i < 16; i++) begin
            wr_en   = (i == 0) || (i == 7);
            wr_addr = 3'd0;
            wr_data = (i == 0) ? 8'd2 : 8'd3;
            step();
            check($sformatf("s4 pwm0 c%0d", i), 32'(pwm_out[0]), 32'(exp_s4_pwm[i]));
        end
        wr_en = 1'b0;

        // Scenario 2: duty1=0 stays inactive, duty2=9 > period=7 stays active
        en     = 1'b0;
        strobe = 1'b0;
        write_reg(3'd6, 8'd7);
        write_reg(3'd1, 8'd0);
        write_reg(3'd2, 8'd9);
        step();
        en     = 1'b1;
        strobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("s2 pwm1 c%0d", i), 32'(pwm_out[1]), 32'h0);
            check($sformatf("s2 pwm2 c%0d", i), 32'(pwm_out[2]), 32'h1);
        end

        // Scenario 5: inverted channel 0, idle level, then strobe every 2nd cycle
        en     = 1'b0;
        strobe = 1'b0;
        write_reg(3'd7, 8'h01);
        write_reg(3'd6, 8'd1);
        write_reg(3'd0, 8'd1);
        step();
        check("s5 idle pwm_out", 32'(pwm_out), 32'h1);
        check("s5 idle period_start", 32'(period_start), 32'h0);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe = (i % 2 == 0);
            step();
            check($sformatf("s5 pwm0 c%0d", i), 32'(pwm_out[0]), 32'(exp_s5_pwm[i]));
            check($sformatf("s5 period_start c%0d", i), 32'(period_start), 32'(exp_s5_ps[i]));
        end

        // Scenario 6: reset mid-period aborts without a period_start pulse
        en     = 1'b0;
        strobe = 1'b0;
        write_reg(3'd6, 8'd3);
        step();
        en     = 1'b1;
        strobe = 1'b1;
        step();
        step();
        check("s6 count before reset", 32'(dut.count_reg), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s6 count", 32'(dut.count_reg), 32'h0);
        check("s6 pwm_out", 32'(pwm_out), 32'h0);
        check("s6 period_start", 32'(period_start), 32'h0);
        check("s6 period", 32'(dut.period_active_reg), 32'd255);

        // period=0 wraps on every strobe
        en     = 1'b0;
        strobe = 1'b0;
        write_reg(3'd6, 8'd0);
        step();
        en     = 1'b1;
        strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("p0 period_start c%0d", i), 32'(period_start), 32'h1);
            check($sformatf("p0 pwm0 c%0d", i), 32'(pwm_out[0]), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
